// File: rtl/fft_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_ctrl_pkg
//  Description : Shared types for the FFT frame sequencer (FSM states, tag).
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_frame_ctrl_pkg;

    localparam int TAG_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Tag bit positions: valid=0, sof=1, eof=2, bad=3
    typedef struct packed {
        logic bad;
        logic eof;
        logic sof;
        logic valid;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/fft_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module      : fft_tag_delay
//  Description : DEPTH-stage shift register with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_tag_delay #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_ctrl
//  Description : Frame sequencer and re-tagger around a 4-lane streaming FFT.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int NBITS = 10,
    parameter int OBITS = 15,
    parameter int N     = 128,
    parameter int LAT   = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_enable,
    input  logic               err_clr,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_sof,
    input  logic [8*NBITS-1:0] s_data,
    output logic [2*NBITS-1:0] fft_in0_up,
    output logic [2*NBITS-1:0] fft_in0_down,
    output logic [2*NBITS-1:0] fft_in1_up,
    output logic [2*NBITS-1:0] fft_in1_down,
    input  logic [2*OBITS-1:0] fft_out0_up,
    input  logic [2*OBITS-1:0] fft_out0_down,
    input  logic [2*OBITS-1:0] fft_out1_up,
    input  logic [2*OBITS-1:0] fft_out1_down,
    output logic               m_valid,
    output logic               m_sof,
    output logic               m_eof,
    output logic               m_bad,
    output logic [8*OBITS-1:0] m_data,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic               err_underrun,
    output logic               err_sync
);

    localparam int                GROUPS   = N / 4;
    localparam int                CNT_W    = $clog2(GROUPS);
    localparam int                SW       = 2 * NBITS;
    localparam logic [CNT_W-1:0]  LAST_GRP = CNT_W'(GROUPS - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_grp_cnt;
    logic               r_frame_bad;
    tag_t               r_tag;
    tag_t               w_tag_dly;

    logic               w_run;
    logic               w_start;
    logic               w_feed;
    logic               w_first;
    logic               w_last;
    logic               w_underrun;
    logic               w_sync;
    logic               w_bad;
    logic [8*NBITS-1:0] w_group;

    assign w_run    = (r_state == ST_RUN);
    assign s_ready  = w_run | cfg_enable;
    assign w_start  = !w_run & cfg_enable & s_valid & s_sof;
    assign w_feed   = w_run | w_start;
    assign w_first  = (r_grp_cnt == '0);
    assign w_last   = (r_grp_cnt == LAST_GRP);

    // The FFT cannot stall: a missing group in RUN becomes a zero group.
    assign w_underrun = w_run & !s_valid;
    // Group 0 must carry sof; any other group must not.
    assign w_sync     = w_run & (w_first ? !(s_valid & s_sof) : (s_valid & s_sof));
    assign w_bad      = (!w_first & r_frame_bad) | w_underrun | w_sync;
    assign w_group    = (w_feed & s_valid) ? s_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            r_grp_cnt    <= '0;
            r_frame_bad  <= 1'b0;
            r_tag        <= '0;
            fft_in0_up   <= '0;
            fft_in0_down <= '0;
            fft_in1_up   <= '0;
            fft_in1_down <= '0;
        end else begin
            fft_in0_up   <= w_group[0*SW +: SW];
            fft_in0_down <= w_group[1*SW +: SW];
            fft_in1_up   <= w_group[2*SW +: SW];
            fft_in1_down <= w_group[3*SW +: SW];

            r_tag.valid  <= w_feed;
            r_tag.sof    <= w_feed & w_first;
            r_tag.eof    <= w_feed & w_last;
            r_tag.bad    <= w_feed & w_bad;

            if (w_feed) begin
                r_frame_bad <= w_bad;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_RUN;
                        busy      <= 1'b1;
                        r_grp_cnt <= CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_grp_cnt <= '0;
                        if (!cfg_enable) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_grp_cnt <= r_grp_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    r_grp_cnt <= '0;
                end
            endcase
        end
    end

    // One stage of r_tag plus LAT here lines the tag up with fft_out*.
    fft_tag_delay #(
        .DEPTH (LAT),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (r_tag),
        .dout (w_tag_dly)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            m_bad   <= 1'b0;
            m_data  <= '0;
        end else begin
            m_valid <= w_tag_dly.valid;
            m_sof   <= w_tag_dly.sof;
            m_eof   <= w_tag_dly.eof;
            m_bad   <= w_tag_dly.bad;
            m_data  <= w_tag_dly.valid ?
                       {fft_out1_down, fft_out1_up, fft_out0_down, fft_out0_up} : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (m_valid & m_eof) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_underrun <= 1'b0;
            err_sync     <= 1'b0;
        end else begin
            err_underrun <= w_underrun | (err_underrun & !err_clr);
            err_sync     <= w_sync     | (err_sync & !err_clr);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_ctrl
//  Description : Randomized self-checking bench with a frame-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;

    localparam int NB  = 10;
    localparam int OB  = 15;
    localparam int LAT = 14;

    logic          clk;
    logic          rst;
    logic          cfg_enable;
    logic          err_clr;
    logic          s_valid;
    logic          s_ready;
    logic          s_sof;
    logic [79:0]   s_data;
    logic [19:0]   fft_in0_up, fft_in0_down, fft_in1_up, fft_in1_down;
    logic [29:0]   fft_out0_up, fft_out0_down, fft_out1_up, fft_out1_down;
    logic          m_valid, m_sof, m_eof, m_bad;
    logic [119:0]  m_data;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic          err_underrun, err_sync;

    fft_frame_ctrl #(.NBITS(NB), .OBITS(OB), .N(128), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .err_clr(err_clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
        .fft_in0_up(fft_in0_up), .fft_in0_down(fft_in0_down),
        .fft_in1_up(fft_in1_up), .fft_in1_down(fft_in1_down),
        .fft_out0_up(fft_out0_up), .fft_out0_down(fft_out0_down),
        .fft_out1_up(fft_out1_up), .fft_out1_down(fft_out1_down),
        .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof), .m_bad(m_bad),
        .m_data(m_data), .busy(busy), .frame_cnt(frame_cnt),
        .err_underrun(err_underrun), .err_sync(err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FFT: pure LAT-cycle delay with a lane-distinguishing mapping.
    function automatic logic [29:0] fmap(input logic [19:0] x);
        return {x[9:0], x};
    endfunction

    function automatic logic [119:0] expand(input logic [79:0] d);
        logic [119:0] r;
        for (int i = 0; i < 4; i++) r[30*i +: 30] = fmap(d[20*i +: 20]);
        return r;
    endfunction

    logic [79:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        for (int i = LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= {fft_in1_down, fft_in1_up, fft_in0_down, fft_in0_up};
    end
    assign fft_out0_up   = fmap(pipe[LAT-1][19:0]);
    assign fft_out0_down = fmap(pipe[LAT-1][39:20]);
    assign fft_out1_up   = fmap(pipe[LAT-1][59:40]);
    assign fft_out1_down = fmap(pipe[LAT-1][79:60]);

    // Reference model state, in frame terms
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    bit           m_run  = 0;
    int           m_idx  = 0;
    bit           m_fbad = 0;
    bit           mu     = 0;
    bit           ms     = 0;
    logic [15:0]  mcnt   = '0;
    logic [79:0]  mfin   = '0;
    logic [123:0] exp_beat [int];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input bit v, input bit sof, input logic [79:0] d,
                        input bit en, input bit clr, input bit rs);
        logic [123:0] e;
        bit feed, ue, se, bad;
        int g;
        s_valid = v; s_sof = sof; s_data = d;
        cfg_enable = en; err_clr = clr; rst = rs;
        #1;
        e = exp_beat.exists(cyc) ? exp_beat[cyc] : '0;
        chk("s_ready",   128'(s_ready), 128'(m_run | en));
        chk("busy",      128'(busy), 128'(m_run));
        chk("m_beat",    128'({m_valid, m_sof, m_eof, m_bad, m_data}), 128'(e));
        chk("frame_cnt", 128'(frame_cnt), 128'(mcnt));
        chk("err_flags", 128'({err_underrun, err_sync}), 128'({mu, ms}));
        chk("fft_in",    128'({fft_in1_down, fft_in1_up, fft_in0_down, fft_in0_up}), 128'(mfin));
        if (e[123] && e[121]) mcnt = mcnt + 16'd1;
        if (rs) begin
            m_run = 0; m_idx = 0; m_fbad = 0; mu = 0; ms = 0; mcnt = '0; mfin = '0;
            for (int k = cyc + 1; k <= cyc + LAT + 2; k++)
                if (exp_beat.exists(k)) exp_beat.delete(k);
        end else begin
            feed = 0; g = 0; ue = 0; se = 0;
            if (m_run) begin
                feed = 1; g = m_idx; ue = !v;
                se = (g != 0) ? (v && sof) : !(v && sof);
            end else if (en && v && sof) begin
                feed = 1; g = 0; m_run = 1;
            end
            mfin = (feed && v) ? d : '0;
            if (feed) begin
                bad = ((g != 0) && m_fbad) || ue || se;
                m_fbad = bad;
                exp_beat[cyc + LAT + 2] = {1'b1, g == 0, g == 31, bad, expand(v ? d : 80'd0)};
                if (g == 31) begin m_idx = 0; m_run = en; end
                else m_idx = g + 1;
            end
            mu = ue || (mu && !clr);
            ms = se || (ms && !clr);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, rnd80(), 0, 0, 0);
    endtask

    // 32-group frame; *_at index selects where each disturbance lands (>31 = none).
    task automatic frame(input int ur_at, input int sof_at, input int en_off_at,
                         input int rst_at, input int clr_at, input bit nosof);
        bit sof;
        for (int g = 0; g < 32; g++) begin
            sof = (g == 0) ? !nosof : (g == sof_at);
            step(g != ur_at, sof, rnd80(), (g < en_off_at) && (g != rst_at),
                 g == clr_at, g == rst_at);
        end
    endtask

    initial begin
        rst = 1; cfg_enable = 0; err_clr = 0; s_valid = 0; s_sof = 0; s_data = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0, 1);

        frame(99, 99, 31, 99, 99, 0);                 // single frame
        idle(20);
        frame(99, 99, 32, 99, 99, 0);                 // back-to-back
        frame(99, 99, 32, 99, 99, 0);
        frame(99, 99, 31, 99, 99, 0);
        idle(20);
        frame(10, 99, 31, 99, 99, 0);                 // underrun
        idle(20);
        step(0, 0, '0, 0, 1, 0);
        idle(2);
        frame(99, 5, 31, 99, 99, 0);                  // sync error
        idle(20);
        step(0, 0, '0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, rnd80(), 1, 0, 0);  // dropped in IDLE
        idle(20);
        frame(99, 99, 20, 99, 99, 0);                 // enable drops mid-frame
        idle(20);
        frame(99, 99, 32, 99, 99, 0);                 // missing sof on next frame
        frame(99, 99, 31, 99, 99, 1);
        idle(20);
        frame(7, 99, 31, 99, 7, 0);                   // set wins over clear
        idle(20);
        step(0, 0, '0, 0, 1, 0);
        frame(99, 99, 32, 15, 99, 0);                 // reset mid-frame
        idle(20);
        for (int r = 0; r < 8; r++)
            frame($urandom_range(0, 60), $urandom_range(1, 60), $urandom_range(18, 32),
                  99, $urandom_range(0, 60), $urandom_range(0, 4) == 0);
        idle(40);
        step(0, 0, '0, 0, 1, 0);

        force dut.frame_cnt = 16'hFFFF;               // counter wrap
        mcnt = 16'hFFFF;
        step(0, 0, '0, 0, 0, 0);
        release dut.frame_cnt;
        frame(99, 99, 31, 99, 99, 0);
        idle(20);
        chk("frame_cnt_wrap", 128'(frame_cnt), 128'(16'h0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
